// File: rtl/regfile_wb_pkg.sv
// Shared widths, requester ids and the write-request payload for the
// register-file writeback arbiter.
package regfile_wb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    localparam logic REQ_LOAD = 1'b0;
    localparam logic REQ_ALU  = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_starve_ctr.sv
// Counts consecutive req1 losses and raises a force-grant flag at the limit.
// Only instantiated when WB_ARB_ANTI_STARVE_EN is defined.
module regfile_wb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic req1_valid_i,
    input  logic req1_ready_i,
    output logic force_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Hold freezes the count; a grant or a dropped request clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (!req1_valid_i || req1_ready_i) begin
            cnt_d = '0;
        end else if (!hold_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_o = req1_valid_i && (cnt_q == LIMIT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Fixed-priority writeback arbiter for the register-file write port; x0 writes
// are dropped. Optional req1 anti-starvation under WB_ARB_ANTI_STARVE_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = regfile_wb_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_wb_pkg::ADDR_W
`ifdef WB_ARB_ANTI_STARVE_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic [DATA_W-1:0] Writedata,
    output logic              last_grant
);

    import regfile_wb_pkg::*;

    logic force_c;

`ifdef WB_ARB_ANTI_STARVE_EN
    regfile_wb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold),
        .req1_valid_i (req1_valid),
        .req1_ready_i (req1_ready),
        .force_o      (force_c)
    );
`else
    assign force_c = 1'b0;
`endif

    logic grant_ok_c;

    // Readies stay low in reset so nothing is accepted while the outputs are cleared.
    assign grant_ok_c = rst_n && !hold;
    assign req0_ready = grant_ok_c && req0_valid && !force_c;
    assign req1_ready = grant_ok_c && req1_valid && (!req0_valid || force_c);

    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              last_q,     last_d;

    // Winner selection and x0 filtering; address/data only move on a real write.
    always_comb begin
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        last_d     = last_q;
        if (req0_ready) begin
            last_d = REQ_LOAD;
            if (req0_addr != ADDR_W'(ZERO_REG)) begin
                regwrite_d = 1'b1;
                waddr_d    = req0_addr;
                wdata_d    = req0_data;
            end
        end else if (req1_ready) begin
            last_d = REQ_ALU;
            if (req1_addr != ADDR_W'(ZERO_REG)) begin
                regwrite_d = 1'b1;
                waddr_d    = req1_addr;
                wdata_d    = req1_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            last_q     <= last_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign WriteAddr  = waddr_q;
    assign Writedata  = wdata_q;
    assign last_grant = last_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model.
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] Writedata;
    logic              last_grant;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] rf [32];

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .Writedata  (Writedata),
        .last_grant (last_grant)
    );

    // Register-file model capturing the write port.
    always @(posedge clk) begin
        if (RegWrite) rf[WriteAddr] <= Writedata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 1'b0; hold = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h12345678;
        tick(); tick();
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_waddr", 64'(WriteAddr), 64'd0);
        check("rst_wdata", 64'(Writedata), 64'd0);
        check("rst_last", 64'(last_grant), 64'd0);
        check("rst_rdy1", 64'(req1_ready), 64'd0);
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single ALU write
        req1_valid = 1'b1; req1_addr = 5'd1; req1_data = 32'hffffeeee;
        #1;
        check("single_rdy1", 64'(req1_ready), 64'd1);
        check("single_rdy0", 64'(req0_ready), 64'd0);
        tick();
        req1_valid = 1'b0;
        check("single_we", 64'(RegWrite), 64'd1);
        check("single_addr", 64'(WriteAddr), 64'd1);
        check("single_data", 64'(Writedata), 64'hffffeeee);
        check("single_last", 64'(last_grant), 64'd1);
        tick();
        check("single_we_off", 64'(RegWrite), 64'd0);
        check("single_addr_hold", 64'(WriteAddr), 64'd1);
        check("single_rf1", 64'(rf[1]), 64'hffffeeee);

        // Same destination from both requesters
        req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h00001111;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22222222;
        #1;
        check("conf_rdy0", 64'(req0_ready), 64'd1);
        check("conf_rdy1", 64'(req1_ready), 64'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("conf_we0", 64'(RegWrite), 64'd1);
        check("conf_data0", 64'(Writedata), 64'h00001111);
        check("conf_last0", 64'(last_grant), 64'd0);
        check("conf_rdy1_b", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("conf_we1", 64'(RegWrite), 64'd1);
        check("conf_data1", 64'(Writedata), 64'h22222222);
        check("conf_last1", 64'(last_grant), 64'd1);
        tick();
        check("conf_rf2", 64'(rf[2]), 64'h22222222);

        // x0 drop
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hdeadbeef;
        #1;
        check("x0_rdy0", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("x0_we", 64'(RegWrite), 64'd0);
        check("x0_last", 64'(last_grant), 64'd0);
        check("x0_addr", 64'(WriteAddr), 64'd2);
        check("x0_data", 64'(Writedata), 64'h22222222);

        // Hold for three cycles with req1 pending
        hold = 1'b1;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h33333333;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_rdy1", 64'(req1_ready), 64'd0);
            tick();
            check("hold_we", 64'(RegWrite), 64'd0);
        end
        hold = 1'b0;
        #1;
        check("hold_rel_rdy1", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        hold = 1'b1;
        #1;
        check("hold_mid_we", 64'(RegWrite), 64'd1);
        check("hold_mid_addr", 64'(WriteAddr), 64'd3);
        tick();
        hold = 1'b0;
        check("hold_mid_we_off", 64'(RegWrite), 64'd0);
        check("hold_rf3", 64'(rf[3]), 64'h33333333);

        // Asynchronous reset with a write in flight
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44444444;
        tick();
        req1_valid = 1'b0;
        check("arst_pre_we", 64'(RegWrite), 64'd1);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5;
        #1;
        check("arst_we", 64'(RegWrite), 64'd0);
        check("arst_addr", 64'(WriteAddr), 64'd0);
        check("arst_data", 64'(Writedata), 64'd0);
        check("arst_last", 64'(last_grant), 64'd0);
        check("arst_rdy0", 64'(req0_ready), 64'd0);
        tick();
        check("arst_hold_we", 64'(RegWrite), 64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Continuous contention
        req0_valid = 1'b1; req0_addr = 5'd6; req0_data = 32'h66666666;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77777777;
`ifdef WB_ARB_ANTI_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_rdy0", 64'(req0_ready), 64'd1);
            check("starve_rdy1", 64'(req1_ready), 64'd0);
            tick();
        end
        #1;
        check("starve_force_rdy1", 64'(req1_ready), 64'd1);
        check("starve_force_rdy0", 64'(req0_ready), 64'd0);
        tick();
        check("starve_force_last", 64'(last_grant), 64'd1);
        check("starve_force_addr", 64'(WriteAddr), 64'd7);
        #1;
        check("starve_resume_rdy0", 64'(req0_ready), 64'd1);
        check("starve_resume_rdy1", 64'(req1_ready), 64'd0);
        req1_valid = 1'b0;
`else
        for (int i = 0; i < 6; i++) begin
            #1;
            check("prio_rdy0", 64'(req0_ready), 64'd1);
            check("prio_rdy1", 64'(req1_ready), 64'd0);
            tick();
        end
        check("prio_last", 64'(last_grant), 64'd0);
        req0_valid = 1'b0;
        #1;
        check("prio_rdy1_free", 64'(req1_ready), 64'd1);
        tick();
        req1_valid = 1'b0;
        check("prio_addr", 64'(WriteAddr), 64'd7);
`endif
        req0_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
